// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding and width helper for the sequence detector
package seq_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MATCH   = 3'd1,
        ST_FAIL    = 3'd2,
        ST_DETECT  = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_ISOLATE = 3'd5,
        ST_TAMPER  = 3'd6
    } state_e;

    // Where an unreachable encoding lands: the most restrictive state.
    localparam state_e FAIL_SAFE_STATE = ST_TAMPER;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_det_timer.sv
// rtl/seq_det_timer.sv - loadable down-counter with a terminal-count flag
module seq_det_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - held-bit serial pattern matcher with lockout, isolation and tamper escalation
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN     = 8,
    parameter logic [PAT_LEN-1:0] PATTERN     = 8'b0011_0110,
    parameter int                 HOLD        = 2,
    parameter int                 INTR_RUN    = 3,
    parameter int                 MAX_FAIL    = 3,
    parameter int                 LOCK_CYCLES = 16,
    parameter int                 MAX_LOCK    = 2
) (
    input  logic                            clk,
    input  logic                            RESET,
    input  logic                            in,
    input  logic                            in_vld,
    input  logic                            tamper_clr,
    output logic                            detect,
    output logic                            isolated,
    output logic                            locked_out,
    output logic                            tamper,
    output logic [$clog2(PAT_LEN+1)-1:0]    progress,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

    if (PAT_LEN < 2 || HOLD < 1 || INTR_RUN < 2 || MAX_FAIL < 1 ||
        LOCK_CYCLES < 1 || MAX_LOCK < 1) begin : g_bad_params
        $error("seq_detector_param: parameter out of range");
    end

    localparam int PW = $clog2(PAT_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int HW = cnt_w(HOLD);
    localparam int IW = cnt_w(INTR_RUN);
    localparam int LW = cnt_w(MAX_LOCK);
    localparam int TW = cnt_w(LOCK_CYCLES);

    localparam logic [PW-1:0] IDX_LAST   = PW'(PAT_LEN - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);
    localparam logic [IW-1:0] INTR_LAST  = IW'(INTR_RUN - 1);
    localparam logic [IW-1:0] INTR_MAX   = IW'(INTR_RUN);
    localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAIL - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(MAX_LOCK - 1);
    localparam logic [LW-1:0] LOCK_MAX   = LW'(MAX_LOCK);
    localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [IW-1:0] intr_q, intr_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          exp_bit;
    logic          tmr_load, tmr_dec, tmr_done;

    seq_det_timer #(.WIDTH(TW)) u_lock_timer (
        .clk      (clk),
        .resetn   (RESET),
        .load     (tmr_load),
        .load_val (LOCK_LOAD),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    always_comb begin
        exp_bit = 1'b0;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (idx_q == PW'(i)) exp_bit = PATTERN[PAT_LEN-1-i];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        intr_d   = intr_q;
        fail_d   = fail_q;
        lock_d   = lock_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: if (in_vld) begin
                if (in == exp_bit) begin
                    intr_d  = '0;
                    hold_d  = '0;
                    state_d = ST_MATCH;
                    if (HOLD == 1) idx_d = PW'(1);
                    else           hold_d = HW'(1);
                end else if (intr_q != INTR_MAX) begin
                    intr_d = intr_q + 1'b1;
                    if (intr_q == INTR_LAST) state_d = ST_ISOLATE;
                end
            end
            ST_MATCH: if (in_vld) begin
                if (in == exp_bit) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        idx_d  = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) state_d = ST_DETECT;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (hold_q != '0) begin
                    // A single wrong sample mid-hold is a glitch: restart this bit only.
                    hold_d = '0;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_DETECT: begin
                fail_d  = '0;
                idx_d   = '0;
                hold_d  = '0;
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                idx_d  = '0;
                hold_d = '0;
                if (fail_q == FAIL_LAST) begin
                    fail_d = '0;
                    if (lock_q != LOCK_MAX) lock_d = lock_q + 1'b1;
                    if (lock_q == LOCK_LAST) begin
                        state_d = ST_TAMPER;
                    end else begin
                        state_d  = ST_LOCKOUT;
                        tmr_load = 1'b1;
                    end
                end else begin
                    fail_d  = fail_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                tmr_dec = 1'b1;
                if (tmr_done) state_d = ST_IDLE;
            end
            ST_ISOLATE, ST_TAMPER: ;
            default: state_d = FAIL_SAFE_STATE;
        endcase
    end

    // Reset cannot release TAMPER on its own, and lock history survives it there.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            state_q <= (state_q == ST_TAMPER && !tamper_clr) ? ST_TAMPER : ST_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            intr_q  <= '0;
            fail_q  <= '0;
            if (state_q != ST_TAMPER || tamper_clr) lock_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            intr_q  <= intr_d;
            fail_q  <= fail_d;
            lock_q  <= lock_d;
        end
    end

    assign detect     = (state_q == ST_DETECT);
    assign isolated   = (state_q == ST_ISOLATE);
    assign locked_out = (state_q == ST_LOCKOUT);
    assign tamper     = (state_q == ST_TAMPER);
    assign progress   = idx_q;
    assign fail_count = fail_q;

endmodule
